// File: rtl/uart_rx_ctrl_pkg.sv
// Shared constants for the UART receive path.
// Bus geometry and the UART chip-select value, register offsets,
// STATUS bit positions, the RXDATA valid bit and the receiver FSM states.
package uart_rx_ctrl_pkg;

  // System bus geometry and UART decode
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned IO_SELECT  = 4;
  localparam logic [IO_SELECT-1:0] UART_SELECT = 4'hA;

  // Register select values (addr[3:2])
  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  // STATUS bit positions
  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_FRAME_ERR = 2;
  localparam int unsigned STAT_OVERRUN   = 3;

  // RXDATA valid bit position
  localparam int unsigned RXDATA_VLD = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Single-clock synchronous byte FIFO for the UART receive path.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   push, wr_data : write request and byte
//   pop         : read request (ignored when empty)
//   rd_data     : head byte (combinational from storage)
//   full, empty, count : occupancy
// A push while full is accepted only if a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 wr_data,
  input  logic                       pop,
  output logic [7:0]                 rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: rxd synchroniser, 8N1 deserialiser FSM,
// RX FIFO and memory-mapped RXDATA/STATUS registers.
// Ports:
//   clk        : core clock
//   reset      : asynchronous active-low reset
//   addr       : bus address (chip select in the top IO_SELECT bits, reg in [3:2])
//   wrt_data   : bus write data (STATUS W1C only)
//   rd_data    : registered read data, zero when data_valid is low
//   we         : 1 = write, 0 = read
//   req_valid  : one-cycle request strobe
//   data_valid : one-cycle acknowledge, cycle after the request
//   rxd        : asynchronous serial input, idle high
//   rx_irq     : level interrupt, FIFO not empty or a sticky error set
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wrt_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  we,
  input  logic                  req_valid,
  output logic                  data_valid,
  input  logic                  rxd,
  output logic                  rx_irq
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned FCW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  // Synchroniser
  logic rxd_meta;
  logic rxd_sync;

  // Receiver FSM
  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             push;
  logic             frame_set;

  // FIFO
  logic [7:0]     fifo_rd_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] count_next;
  logic           pop;
  logic           push_ok;
  logic           ovr_set;

  // Bus and flags
  logic                  sel;
  logic                  rd_req;
  logic                  wr_req;
  logic [1:0]            reg_sel;
  logic                  clr_ovr;
  logic                  clr_fe;
  logic                  overrun, overrun_next;
  logic                  frame_err, frame_err_next;
  logic [DATA_WIDTH-1:0] rd_next;

  logic unused_bits;
  assign unused_bits = ^{wrt_data[DATA_WIDTH-1:4], wrt_data[1:0],
                         addr[ADDR_WIDTH-IO_SELECT-1:4], addr[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + CNT_W'(1);
    bit_idx_next = bit_idx;
    shift_next   = shift;
    push         = 1'b0;
    frame_set    = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (!rxd_sync) state_next = S_START;
      end
      S_START: begin
        // Mid-start-bit check filters glitches shorter than half a bit
        if (cnt == HALF_BIT) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rxd_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == FULL_BIT) begin
          cnt_next   = '0;
          shift_next = {rxd_sync, shift[7:1]};
          if (bit_idx == 3'd7) state_next = S_STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt == FULL_BIT) begin
          cnt_next = '0;
          if (rxd_sync) begin
            push       = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_set  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // A held-low line must return high before a new start bit counts
        cnt_next = '0;
        if (rxd_sync) state_next = S_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = S_IDLE;
      end
    endcase
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (shift),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    sel     = req_valid & (addr[ADDR_WIDTH-1 -: IO_SELECT] == UART_SELECT);
    reg_sel = addr[3:2];
    rd_req  = sel & ~we;
    wr_req  = sel & we;
    pop     = rd_req & (reg_sel == REG_RXDATA) & ~fifo_empty;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push
    push_ok = push & (~fifo_full | pop);
    ovr_set = push & fifo_full & ~pop;
    count_next = fifo_count + FCW'(push_ok) - FCW'(pop);

    clr_ovr = wr_req & (reg_sel == REG_STATUS) & wrt_data[STAT_OVERRUN];
    clr_fe  = wr_req & (reg_sel == REG_STATUS) & wrt_data[STAT_FRAME_ERR];
    overrun_next   = ovr_set   | (overrun   & ~clr_ovr);
    frame_err_next = frame_set | (frame_err & ~clr_fe);

    rd_next = '0;
    if (rd_req) begin
      if (reg_sel == REG_RXDATA) begin
        if (!fifo_empty) begin
          rd_next[7:0]       = fifo_rd_data;
          rd_next[RXDATA_VLD] = 1'b1;
        end
      end else if (reg_sel == REG_STATUS) begin
        rd_next[STAT_NOT_EMPTY] = ~fifo_empty;
        rd_next[STAT_FULL]      = fifo_full;
        rd_next[STAT_FRAME_ERR] = frame_err;
        rd_next[STAT_OVERRUN]   = overrun;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      rd_data    <= '0;
      data_valid <= 1'b0;
      rx_irq     <= 1'b0;
    end else begin
      overrun    <= overrun_next;
      frame_err  <= frame_err_next;
      rd_data    <= rd_next;
      data_valid <= sel;
      rx_irq     <= (count_next != '0) | overrun_next | frame_err_next;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a byte-queue reference model and a
// scoreboard of expected bus read data.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int unsigned CPB = 16;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic [ADDR_WIDTH-1:0] addr = '0;
  logic [DATA_WIDTH-1:0] wrt_data = '0;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  we = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  data_valid;
  logic                  rxd = 1'b1;
  logic                  rx_irq;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0]  mq[$];
  logic [31:0] exp_q[$];
  logic        m_ovr = 1'b0;
  logic        m_fe  = 1'b0;

  uart_rx_ctrl #(
    .CLK_FREQ  (160),
    .BAUD_RATE (10),
    .FIFO_DEPTH(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wrt_data  (wrt_data),
    .rd_data   (rd_data),
    .we        (we),
    .req_valid (req_valid),
    .data_valid(data_valid),
    .rxd       (rxd),
    .rx_irq    (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_model();
    logic [31:0] s;
    s = '0;
    s[STAT_NOT_EMPTY] = (mq.size() != 0);
    s[STAT_FULL]      = (mq.size() == 16);
    s[STAT_FRAME_ERR] = m_fe;
    s[STAT_OVERRUN]   = m_ovr;
    return s;
  endfunction

  function automatic logic [31:0] irq_model();
    return {31'b0, (mq.size() != 0) | m_ovr | m_fe};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [1:0] off);
    return {UART_SELECT, 24'b0, off, 2'b00};
  endfunction

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_rd(input logic [1:0] off, input string tag);
    logic [31:0] e;
    logic [7:0]  b;
    e = '0;
    if (off == REG_RXDATA) begin
      if (mq.size() != 0) begin
        b = mq.pop_front();
        e = {23'b0, 1'b1, b};
      end
    end else if (off == REG_STATUS) begin
      e = status_model();
    end
    exp_q.push_back(e);
    @(negedge clk);
    addr = reg_addr(off); we = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " data_valid"}, {31'b0, data_valid}, 32'd1);
    check(tag, rd_data, exp_q.pop_front());
    check({tag, " irq"}, {31'b0, rx_irq}, irq_model());
    @(negedge clk);
    check({tag, " idle rd_data"}, rd_data, 32'd0);
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [31:0] d, input string tag);
    if (off == REG_STATUS) begin
      if (d[STAT_OVERRUN])   m_ovr = 1'b0;
      if (d[STAT_FRAME_ERR]) m_fe  = 1'b0;
    end
    @(negedge clk);
    addr = reg_addr(off); we = 1'b1; wrt_data = d; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; we = 1'b0; wrt_data = '0;
    check({tag, " data_valid"}, {31'b0, data_valid}, 32'd1);
    check({tag, " rd_data"}, rd_data, 32'd0);
    check({tag, " irq"}, {31'b0, rx_irq}, irq_model());
  endtask

  // One 8N1 frame; with mid_read an RXDATA read is placed in the cycle
  // in which the stop bit is sampled and the byte is pushed.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit mid_read);
    logic [7:0] hb;
    for (int c = 0; c < 10 * CPB; c++) begin
      @(negedge clk);
      if (c / CPB == 0)      rxd = 1'b0;
      else if (c / CPB == 9) rxd = stop;
      else                   rxd = b[c / CPB - 1];
      req_valid = 1'b0;
      if (mid_read && c == 154) begin
        hb = mq.pop_front();
        exp_q.push_back({23'b0, 1'b1, hb});
        addr = reg_addr(REG_RXDATA); we = 1'b0; req_valid = 1'b1;
      end
      if (mid_read && c == 155) begin
        check("mid read data_valid", {31'b0, data_valid}, 32'd1);
        check("mid read rd_data", rd_data, exp_q.pop_front());
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rxd = 1'b1;
    if (stop) begin
      if (mq.size() == 16) m_ovr = 1'b1;
      else                 mq.push_back(b);
    end else begin
      m_fe = 1'b1;
    end
    idle(4);
  endtask

  initial begin
    // 1: reset, then reset again in the middle of a frame
    idle(3);
    reset = 1'b1;
    idle(3);
    rxd = 1'b0;
    idle(40);
    reset = 1'b0;
    #1;
    check("reset rd_data", rd_data, 32'd0);
    check("reset data_valid", {31'b0, data_valid}, 32'd0);
    check("reset irq", {31'b0, rx_irq}, 32'd0);
    rxd = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(40);
    bus_rd(REG_STATUS, "t1 status");
    bus_rd(REG_RXDATA, "t1 rxdata empty");

    // 2: single byte
    send_frame(8'hA5, 1'b1, 1'b0);
    check("t2 irq after rx", {31'b0, rx_irq}, 32'd1);
    bus_rd(REG_RXDATA, "t2 rxdata");
    bus_rd(REG_RXDATA, "t2 rxdata second");
    bus_rd(2'd2, "t2 other offset");

    // 3: short glitch
    @(negedge clk);
    rxd = 1'b0;
    idle(6);
    rxd = 1'b1;
    idle(40);
    bus_rd(REG_STATUS, "t3 status");

    // 4: framing error and W1C clear
    send_frame(8'h3C, 1'b0, 1'b0);
    bus_rd(REG_STATUS, "t4 status fe");
    bus_wr(REG_STATUS, 32'h4, "t4 clear fe");
    bus_rd(REG_STATUS, "t4 status cleared");

    // 5: overflow
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
    bus_rd(REG_STATUS, "t5 status ovr");
    for (int i = 0; i < 16; i++) bus_rd(REG_RXDATA, "t5 drain");
    bus_rd(REG_STATUS, "t5 status after drain");
    bus_wr(REG_STATUS, 32'h8, "t5 clear ovr");
    bus_rd(REG_STATUS, "t5 status cleared");

    // 6: pop and push in the same cycle while full
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1, 1'b0);
    send_frame(8'h30, 1'b1, 1'b1);
    bus_rd(REG_STATUS, "t6 status full");
    for (int i = 0; i < 16; i++) bus_rd(REG_RXDATA, "t6 drain");
    bus_rd(REG_STATUS, "t6 status end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
